// File: rtl/gemm_sched_pkg.sv
// Shared types and width helpers for the dot-product stream sequencer.
package gemm_sched_pkg;

    localparam int unsigned LANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } dp_tag_t;

    // Signed 8-lane dot product of DATA_WIDTH operands: product bits plus lane-sum growth.
    function automatic int unsigned res_width(input int unsigned data_width);
        return 2 * data_width + 3;
    endfunction

    // Accumulator wide enough to sum max_beats datapath results without overflow.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned max_beats);
        return res_width(data_width) + $clog2(max_beats);
    endfunction

endpackage

// File: rtl/sched_tag_pipe.sv
// Enable-gated shift register carrying beat tags alongside the datapath pipeline.
module sched_tag_pipe
    import gemm_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  dp_tag_t din,
    output dp_tag_t dout
);

    dp_tag_t stage_q [DEPTH];

    // Shift tags one stage per enabled cycle; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dot8_stream_sched.sv
// Job sequencer for one 8-lane dot-product datapath: feeds beats, tracks
// in-flight tags and accumulates the per-beat results into one job result.
module dot8_stream_sched
    import gemm_sched_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DP_LAT     = 3,
    parameter  int unsigned MAX_BEATS  = 256,
    localparam int unsigned RES_W      = res_width(DATA_WIDTH),
    localparam int unsigned LEN_W      = $clog2(MAX_BEATS + 1),
    localparam int unsigned ACC_W      = acc_width(DATA_WIDTH, MAX_BEATS),
    localparam int unsigned VEC_W      = LANES * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    cfg_err,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VEC_W-1:0]        in_a,
    input  logic [VEC_W-1:0]        in_b,
    output logic                    dp_ena,
    output logic [VEC_W-1:0]        dp_a,
    output logic [VEC_W-1:0]        dp_b,
    input  logic signed [RES_W-1:0] dp_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_res
);

    sched_state_e state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             clr_acc;
    logic [VEC_W-1:0] a_d, b_d;
    dp_tag_t          tag_d, tag_q, tag_out;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] res_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    len_ok;
    logic                    acc_en;
    logic                    last_exit;

    assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_BEATS));
    assign res_ext   = ACC_W'(dp_res);
    assign acc_sum   = acc_q + res_ext;
    assign acc_en    = dp_ena && tag_out.valid;
    assign last_exit = acc_en && tag_out.last;

    // Next-state, beat counting and operand/tag selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        clr_acc = 1'b0;
        tag_d   = '0;
        a_d     = '0;
        b_d     = '0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (len_ok) begin
                        cnt_d   = cfg_len;
                        clr_acc = 1'b1;
                        state_d = FEED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (in_valid && in_ready) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    tag_d.valid = 1'b1;
                    cnt_d       = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        tag_d.last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_exit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and remaining-beat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control outputs registered from the upcoming state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            dp_ena    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            in_ready  <= (state_d == FEED);
            dp_ena    <= (state_d == FEED) || (state_d == DRAIN);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == DONE);
            cfg_err   <= err_d;
        end
    end

    // Operand drive stage; the tag launched with each beat rides with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a  <= '0;
            dp_b  <= '0;
            tag_q <= '0;
        end else if (dp_ena) begin
            dp_a  <= a_d;
            dp_b  <= b_d;
            tag_q <= tag_d;
        end
    end

    sched_tag_pipe #(
        .DEPTH (DP_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_ena),
        .din   (tag_q),
        .dout  (tag_out)
    );

    // Accumulate valid beats; the last beat's sum becomes the held job result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            out_res <= '0;
        end else begin
            if (clr_acc) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_sum;
            end
            if (last_exit) begin
                out_res <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_dot8_stream_sched.sv
// Directed bench for dot8_stream_sched with a behavioural 3-stage datapath.
module tb_dot8_stream_sched;

    localparam int unsigned DW    = 8;
    localparam int unsigned LAT   = 3;
    localparam int unsigned RES_W = 19;
    localparam int unsigned LEN_W = 9;
    localparam int unsigned ACC_W = 27;
    localparam int unsigned VEC_W = 64;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_start;
    logic [LEN_W-1:0]        cfg_len;
    logic                    cfg_err;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [VEC_W-1:0]        in_a;
    logic [VEC_W-1:0]        in_b;
    logic                    dp_ena;
    logic [VEC_W-1:0]        dp_a;
    logic [VEC_W-1:0]        dp_b;
    logic signed [RES_W-1:0] dp_res;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dot8_stream_sched #(
        .DATA_WIDTH (DW),
        .DP_LAT     (LAT),
        .MAX_BEATS  (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_len   (cfg_len),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .dp_ena    (dp_ena),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_res    (dp_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    // Behavioural datapath: signed 8-lane dot product, LAT enabled stages.
    function automatic logic signed [RES_W-1:0] dot8(input logic [VEC_W-1:0] a,
                                                      input logic [VEC_W-1:0] b);
        int s;
        logic [7:0] ea, eb;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            ea = a[i*8 +: 8];
            eb = b[i*8 +: 8];
            s += int'($signed(ea)) * int'($signed(eb));
        end
        return RES_W'(s);
    endfunction

    logic signed [RES_W-1:0] dp_pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) dp_pipe[i] <= '0;
        end else if (dp_ena) begin
            dp_pipe[0] <= dot8(dp_a, dp_b);
            for (int i = 1; i < int'(LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end

    assign dp_res = dp_pipe[LAT-1];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] splat(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic start_job(input int len);
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(len);
        step();
        cfg_start = 1'b0;
        cfg_len   = '0;
    endtask

    // Present one beat and hold it until the handshake edge has passed.
    task automatic feed(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        int  n;
        logic hs;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        do begin
            hs = in_ready;
            step();
            n++;
        end while (!hs && n < 50);
        if (!hs) check("feed_timeout", 0, 1);
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_dp_ena", dp_ena, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        check("rst_out_res", out_res, 0);
        rst_n = 1'b1;
        step();

        // Single beat: 8 * (1*2) = 16, result four cycles after the handshake.
        start_job(1);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        feed(splat(8'd1), splat(8'd2));
        wait_valid(n);
        check("t1_latency", n, 4);
        check("t1_res", out_res, 16);
        consume();
        check("t1_idle", busy, 0);

        // Four beats with bubbles: 4 * 8 * (-3*5) = -480.
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            feed(splat(8'hFD), splat(8'd5));
            step();
        end
        wait_valid(n);
        check("t2_res", out_res, -480);
        consume();

        // Full-length job: 256 * 8 * 16384 = 33554432.
        start_job(256);
        for (int i = 0; i < 256; i++) feed(splat(8'h80), splat(8'h80));
        wait_valid(n);
        check("t3_res", out_res, 33554432);
        consume();
        check("t3_idle", busy, 0);

        // Rejected lengths.
        start_job(0);
        check("t4_err0", cfg_err, 1);
        check("t4_busy0", busy, 0);
        check("t4_ena0", dp_ena, 0);
        step();
        check("t4_err0_pulse", cfg_err, 0);
        start_job(257);
        check("t4_err257", cfg_err, 1);
        check("t4_busy257", busy, 0);
        check("t4_ena257", dp_ena, 0);
        step();
        check("t4_err257_pulse", cfg_err, 0);

        // Backpressure in DONE: 2 * 8 * (3 * -1) = -48 held; start ignored.
        start_job(2);
        feed(splat(8'd3), splat(8'hFF));
        feed(splat(8'd3), splat(8'hFF));
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                cfg_start = 1'b1;
                cfg_len   = LEN_W'(1);
            end
            step();
            cfg_start = 1'b0;
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_res", out_res, -48);
            check("t5_no_err", cfg_err, 0);
        end
        consume();
        check("t5_idle", busy, 0);
        check("t5_valid_drop", out_valid, 0);

        // Reset mid-job, then a fresh job: 8*(2*3) + 8*(1*7) = 104.
        start_job(5);
        feed(splat(8'd10), splat(8'd10));
        feed(splat(8'd10), splat(8'd10));
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_dp_ena", dp_ena, 0);
        check("t6_rst_out_res", out_res, 0);
        step();
        rst_n = 1'b1;
        step();
        start_job(2);
        feed(splat(8'd2), splat(8'd3));
        feed(splat(8'd1), splat(8'd7));
        wait_valid(n);
        check("t6_res", out_res, 104);
        consume();
        check("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
